// File: rtl/pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer
//
// Control sequencer that sits directly in front of one MAC processing element.
// A command (op, len, bias) is accepted in IDLE. The sequencer then streams
// len operand pairs into the PE, seeding the accumulator with the bias on the
// first pair. It runs one finalisation pass (raw, saturate-to-8 or ReLU) and
// presents the PE result on a valid/ready port. Only one command is in flight
// at a time, and the PE accumulator belongs to this block alone.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_len, cmd_bias       0=RAW 1=SAT8 2=RELU 3=RAW; pair count; seed
//   op_valid/op_ready, op_a, op_b   operand-pair handshake and data
//   pe_a, pe_b, pe_c                PE data inputs (operands, latched bias)
//   pe_mux_*                        PE datapath selects
//   pe_enable_acc                   PE accumulator write enable
//   pe_r                            PE result (acc[7:0] with pe_mux_comb=0)
//   res_valid/res_ready, res_data   result handshake and data
// ---------------------------------------------------------------------------
module pe_mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_bias,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic [7:0]       pe_a,
  output logic [7:0]       pe_b,
  output logic [7:0]       pe_c,
  output logic [1:0]       pe_mux_add_a,
  output logic [1:0]       pe_mux_add_b,
  output logic [1:0]       pe_mux_sat8,
  output logic [1:0]       pe_mux_res,
  output logic             pe_mux_c_acc,
  output logic             pe_mux_relu,
  output logic             pe_mux_comb,
  output logic             pe_enable_acc,
  input  logic [7:0]       pe_r,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0]       OP_SAT8 = 2'd1;
  localparam logic [1:0]       OP_RELU = 2'd2;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q,   len_d;
  logic [1:0]       op_q,    op_d;
  logic [7:0]       bias_q,  bias_d;

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    op_d    = op_q;
    bias_d  = bias_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          len_d   = cmd_len;
          bias_d  = cmd_bias;
          count_d = '0;
          state_d = (cmd_len != '0) ? S_ACC : S_FINAL;
        end
      end
      S_ACC: begin
        if (op_valid) begin
          count_d = count_q + ONE;
          // len is never 0 in ACC, so len-1 cannot wrap.
          if (count_q == len_q - ONE) state_d = S_FINAL;
        end
      end
      S_FINAL: state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      op_q    <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      op_q    <= op_d;
      bias_q  <= bias_d;
    end
  end

  // Output decode. Everything depends on the registered state, except the
  // operand path and the ACC write enable, which follow the operand handshake
  // in the same cycle.
  always_comb begin
    cmd_ready     = 1'b0;
    op_ready      = 1'b0;
    pe_a          = '0;
    pe_b          = '0;
    pe_c          = '0;
    pe_mux_add_a  = '0;
    pe_mux_add_b  = '0;
    pe_mux_sat8   = '0;
    pe_mux_res    = '0;
    pe_mux_c_acc  = 1'b0;
    pe_mux_relu   = 1'b0;
    pe_mux_comb   = 1'b0;
    pe_enable_acc = 1'b0;
    res_valid     = 1'b0;
    res_data      = '0;
    unique case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_ACC: begin
        op_ready      = 1'b1;
        pe_a          = op_a;
        pe_b          = op_b;
        pe_c          = bias_q;
        pe_mux_add_a  = 2'd1;              // product term
        pe_mux_add_b  = 2'd1;              // c/acc term
        pe_mux_res    = 2'd1;              // 12-bit saturated sum
        pe_mux_c_acc  = (count_q == '0);   // first pair is seeded from bias
        pe_enable_acc = op_valid;
      end
      S_FINAL: begin
        pe_c          = bias_q;
        // With len=0 the accumulator was never seeded, so bias feeds directly.
        pe_mux_c_acc  = (len_q == '0);
        pe_enable_acc = 1'b1;
        if (op_q == OP_SAT8) begin
          pe_mux_sat8 = 2'd0;
          pe_mux_res  = 2'd2;
        end else if (op_q == OP_RELU) begin
          pe_mux_sat8 = 2'd0;
          pe_mux_relu = 1'b1;
          pe_mux_res  = 2'd3;
        end else begin
          // RAW and reserved op: add zero, so the accumulator is rewritten unchanged.
          pe_mux_add_a = 2'd3;
          pe_mux_add_b = 2'd1;
          pe_mux_res   = 2'd1;
        end
      end
      S_DONE: begin
        // The accumulator is not written here, so pe_r holds while stalled.
        res_valid = 1'b1;
        res_data  = pe_r;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_sequencer
//
// Drives pe_mac_sequencer through directed and random commands. A small
// behavioural PE reacts to the select lines and feeds pe_r back. Results are
// compared with a reference model that computes each command's answer with
// plain arithmetic: seed, saturating sum of (a*b)>>4, then the final op.
// ---------------------------------------------------------------------------
module tb_pe_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len, cmd_bias;
  logic       op_valid, op_ready;
  logic [7:0] op_a, op_b, pe_a, pe_b, pe_c, pe_r, res_data;
  logic [1:0] pe_mux_add_a, pe_mux_add_b, pe_mux_sat8, pe_mux_res;
  logic       pe_mux_c_acc, pe_mux_relu, pe_mux_comb, pe_enable_acc;
  logic       res_valid, res_ready;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int pe_acc      = 0;
  int pa[16];
  int pb[16];

  pe_mac_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_bias(cmd_bias),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
    .pe_mux_add_a(pe_mux_add_a), .pe_mux_add_b(pe_mux_add_b),
    .pe_mux_sat8(pe_mux_sat8), .pe_mux_res(pe_mux_res),
    .pe_mux_c_acc(pe_mux_c_acc), .pe_mux_relu(pe_mux_relu),
    .pe_mux_comb(pe_mux_comb), .pe_enable_acc(pe_enable_acc),
    .pe_r(pe_r),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int sat(input int v, input int bits);
    int hi;
    int lo;
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  // Behavioural PE: the accumulator is written on each enabled clock edge.
  function automatic int pe_next();
    int add_a;
    int add_b;
    int cacc;
    int s8;
    add_a = (pe_mux_add_a == 2'd1) ? ((int'(pe_a) * int'(pe_b)) >>> 4) : 0;
    cacc  = pe_mux_c_acc ? int'($signed(pe_c)) : pe_acc;
    add_b = (pe_mux_add_b == 2'd1) ? cacc : 0;
    s8    = sat((pe_mux_sat8 == 2'd0) ? cacc : 0, 8);
    case (pe_mux_res)
      2'd1:    return sat(add_a + add_b, 12);
      2'd2:    return s8;
      2'd3:    return (pe_mux_relu && s8 < 0) ? 0 : s8;
      default: return pe_acc;
    endcase
  endfunction

  always @(posedge clk) if (pe_enable_acc) pe_acc <= pe_next();
  assign pe_r = pe_mux_comb ? 8'h00 : 8'(pe_acc);

  // Expected result of one command, computed directly from the command fields.
  function automatic logic [7:0] ref_result(input int op, input int len, input int bias);
    int acc;
    acc = bias;
    for (int i = 0; i < len; i++) acc = sat(acc + (pa[i] * pb[i]) / 16, 12);
    if (op == 1) acc = sat(acc, 8);
    else if (op == 2) acc = (sat(acc, 8) < 0) ? 0 : sat(acc, 8);
    return 8'(acc);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one command from IDLE to its result handshake. Call it and leave it
  // at a negedge. gap: 0 back-to-back, 1 alternate op_valid, 2 random.
  // hold keeps cmd_valid asserted for the whole command.
  task automatic do_cmd(input int op, input int len, input int bias8,
                        input int gap, input int stall, input bit hold);
    int          t0;
    int          idx;
    int          k;
    bit          hs;
    logic [7:0]  exp;
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_len   = 8'(len);
    cmd_bias  = 8'(bias8);
    #1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    t0  = cycle;
    exp = ref_result(op, len, int'($signed(8'(bias8))));
    @(posedge clk); @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
    idx = 0;
    k   = 0;
    while (idx < len && k < 4 * len + 10) begin
      op_valid = (gap == 0) ? 1'b1 : (gap == 1) ? k[0] : 1'($urandom_range(0, 1));
      op_a = 8'(pa[idx]);
      op_b = 8'(pb[idx]);
      #1;
      check("acc_op_ready",  32'(op_ready),      32'd1);
      check("acc_cmd_ready", 32'(cmd_ready),     32'd0);
      check("acc_enable",    32'(pe_enable_acc), 32'(op_valid));
      check("acc_c_seed",    32'(pe_mux_c_acc),  32'(idx == 0));
      check("acc_pe_a",      32'(pe_a),          32'(op_a));
      hs = op_valid && op_ready;
      @(posedge clk); @(negedge clk);
      if (hs) idx++;
      k++;
    end
    if (idx < len) check("op_budget", 32'(idx), 32'(len));
    op_valid = 1'b0;
    op_a     = 8'($urandom);
    #1;
    check("final_enable",    32'(pe_enable_acc), 32'd1);
    check("final_op_ready",  32'(op_ready),      32'd0);
    check("final_cmd_ready", 32'(cmd_ready),     32'd0);
    check("final_pe_a_zero", 32'(pe_a),          32'd0);
    k = 0;
    while (!res_valid && k < 8) begin
      @(posedge clk); @(negedge clk);
      k++;
    end
    check("res_valid_seen", 32'(res_valid), 32'd1);
    if (gap == 0) check("latency", 32'(cycle - t0), 32'(len + 2));
    check("res_data",    32'(res_data),      32'(exp));
    check("done_enable", 32'(pe_enable_acc), 32'd0);
    for (int s = 0; s < stall; s++) begin
      res_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("stall_valid",     32'(res_valid), 32'd1);
      check("stall_data",      32'(res_data),  32'(exp));
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    #1;
    check("post_res_valid", 32'(res_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  task automatic set_pairs(input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3);
    pa[0] = a0; pb[0] = b0; pa[1] = a1; pb[1] = b1;
    pa[2] = a2; pb[2] = b2; pa[3] = a3; pb[3] = b3;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_bias = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready),     32'd1);
    check("rst_op_ready",  32'(op_ready),      32'd0);
    check("rst_res_valid", 32'(res_valid),     32'd0);
    check("rst_enable",    32'(pe_enable_acc), 32'd0);
    check("rst_res_data",  32'(res_data),      32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RAW len=3 bias=2 -> 0x62, latency T+5
    set_pairs(16, 16, 32, 16, 16, 48, 0, 0);
    do_cmd(0, 3, 2, 0, 0, 1'b0);
    // SAT8 and RAW with four saturating pairs
    set_pairs(255, 255, 255, 255, 255, 255, 255, 255);
    do_cmd(1, 4, 0, 0, 0, 1'b0);
    do_cmd(0, 4, 0, 0, 1, 1'b0);
    // RELU len=0 with a negative bias
    do_cmd(2, 0, 8'hF0, 0, 0, 1'b0);
    // SAT8 and RAW with len=0
    do_cmd(1, 0, 8'h85, 0, 0, 1'b0);
    do_cmd(0, 0, 8'h85, 0, 0, 1'b0);
    // Test 1 repeated with gapped operands and a 3-cycle result stall
    set_pairs(16, 16, 32, 16, 16, 48, 0, 0);
    do_cmd(0, 3, 2, 1, 3, 1'b0);

    // Reset after the second pair of a len=4 command
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_len = 8'd4; cmd_bias = 8'd5;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    op_valid  = 1'b1; op_a = 8'd16; op_b = 8'd16;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready),     32'd1);
    check("midrst_op_ready",  32'(op_ready),      32'd0);
    check("midrst_enable",    32'(pe_enable_acc), 32'd0);
    check("midrst_pe_a",      32'(pe_a),          32'd0);
    check("midrst_res_valid", 32'(res_valid),     32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("postrst_res_valid", 32'(res_valid), 32'd0);
    set_pairs(16, 16, 0, 0, 0, 0, 0, 0);
    do_cmd(0, 1, 0, 0, 0, 1'b0);

    // Reserved op behaves as RAW, with cmd_valid held high throughout
    set_pairs(16, 16, 32, 16, 16, 48, 0, 0);
    do_cmd(3, 3, 2, 0, 2, 1'b1);
    do_cmd(3, 3, 2, 0, 0, 1'b0);

    // Random commands
    for (int n = 0; n < 24; n++) begin
      int len;
      len = int'($urandom_range(0, 8));
      for (int i = 0; i < len; i++) begin
        pa[i] = int'($urandom_range(0, 255));
        pb[i] = int'($urandom_range(0, 255));
      end
      do_cmd(int'($urandom_range(0, 3)), len, int'($urandom_range(0, 255)),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
